// File: rtl/datamem_sized.sv
// Byte-addressed big-endian data memory for the MEM stage: byte/half/word
// loads and stores behind a req/ready/done handshake with WAIT wait states.
module datamem_sized #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned WAIT        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] di,
    output logic        ready,
    output logic        done,
    output logic [31:0] dout,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT > 0) ? CW'(WAIT - 1) : '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [AW-1:0] addr;
        logic [31:0]   di;
    } acc_t;

    logic [7:0]    mem [DEPTH_BYTES];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    acc_t          acc_q, acc_d, acc_in, cur;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   dout_q, dout_d;

    logic          accept, commit, bad, wr_en;
    logic [AW-1:0] ad0, ad1, ad2, ad3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   load_val;
    logic          unused_addr_hi;

    assign unused_addr_hi = &{1'b0, a[31:AW]};

    assign acc_in = '{we: we, size: size, uns: uns, addr: a[AW-1:0], di: di};

    // With zero wait states the access commits on the accept edge, so use live inputs.
    assign cur    = (state_q == S_IDLE) ? acc_in : acc_q;
    assign accept = (state_q == S_IDLE) && ready_q && req;
    assign commit = (WAIT == 0) ? accept : ((state_q == S_WAIT) && (cnt_q == '0));

    // Alignment / legality of the access being committed
    always_comb begin
        bad = 1'b0;
        case (cur.size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = cur.addr[0];
            SZ_WORD: bad = (cur.addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    assign wr_en = commit && cur.we && !bad;

    assign ad0 = cur.addr;
    assign ad1 = cur.addr + AW'(1);
    assign ad2 = cur.addr + AW'(2);
    assign ad3 = cur.addr + AW'(3);

    assign b0 = mem[ad0];
    assign b1 = mem[ad1];
    assign b2 = mem[ad2];
    assign b3 = mem[ad3];

    // Big-endian load assembly with sign/zero extension
    always_comb begin
        load_val = '0;
        case (cur.size)
            SZ_BYTE: load_val = {{24{cur.uns ? 1'b0 : b0[7]}}, b0};
            SZ_HALF: load_val = {{16{cur.uns ? 1'b0 : b0[7]}}, b0, b1};
            SZ_WORD: load_val = {b0, b1, b2, b3};
            default: load_val = '0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        dout_d  = dout_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    acc_d   = acc_in;
                    ready_d = 1'b0;
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            done_d = 1'b1;
            err_d  = bad;
            dout_d = (bad || cur.we) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (cur.size)
                SZ_BYTE: begin
                    mem[ad0] <= cur.di[7:0];
                end
                SZ_HALF: begin
                    mem[ad0] <= cur.di[15:8];
                    mem[ad1] <= cur.di[7:0];
                end
                default: begin
                    mem[ad0] <= cur.di[31:24];
                    mem[ad1] <= cur.di[23:16];
                    mem[ad2] <= cur.di[15:8];
                    mem[ad3] <= cur.di[7:0];
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign err   = err_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_datamem_sized.sv
// Bench for datamem_sized: directed and random accesses against a byte-array
// reference model, plus wait-state throughput and reset-abort behaviour.
module tb_datamem_sized;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned W1    = 1;
    localparam int unsigned W3    = 3;

    logic        clk, rst_n;
    logic        req, we, uns, ready, done, err;
    logic [1:0]  size;
    logic [31:0] a, di, dout;
    logic        req3, we3, uns3, ready3, done3, err3;
    logic [1:0]  size3;
    logic [31:0] a3, di3, dout3;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] rd, old30;
    logic        re;
    int          ndone;

    datamem_sized #(.DEPTH_BYTES(DEPTH), .WAIT(W1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .a(a), .di(di), .ready(ready), .done(done), .dout(dout), .err(err)
    );

    datamem_sized #(.DEPTH_BYTES(DEPTH), .WAIT(W3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .size(size3), .uns(uns3),
        .a(a3), .di(di3), .ready(ready3), .done(done3), .dout(dout3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a plain byte array, big-endian numbers built arithmetically
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  output logic [31:0] exp_do, output logic exp_err);
        int     n, base;
        longint v;
        base    = int'(addr % DEPTH);
        n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        exp_err = (n == 0) || (base % n != 0);
        exp_do  = 32'h0;
        if (exp_err) return;
        if (w) begin
            for (int i = 0; i < n; i++)
                ref_mem[base + i] = 8'(data >> (8 * (n - 1 - i)));
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v = v * 256 + longint'(ref_mem[base + i]);
            if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            exp_do = 32'(v);
        end
    endfunction

    task automatic run(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] addr, input logic [31:0] data, input string tag,
                       output logic [31:0] rdo, output logic rerr);
        logic [31:0] e_do;
        logic        e_err;
        int          n;
        model(w, sz, u, addr, data, e_do, e_err);
        @(negedge clk);
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        we = w; size = sz; uns = u; a = addr; di = data; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        a = $urandom; di = $urandom;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(W1 + 1));
        chk({tag, ".do"}, dout, e_do);
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".busy"}, 32'(ready), 32'd0);
        rdo  = dout;
        rerr = err;
        @(posedge clk);
        #1;
        chk({tag, ".hold"}, dout, e_do);
        chk({tag, ".pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; a = '0; di = '0;
        req3 = 1'b0; we3 = 1'b0; size3 = 2'd0; uns3 = 1'b0; a3 = '0; di3 = '0;
        #22;
        chk("rst.ready", 32'(ready), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.do", dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.ready_after", 32'(ready), 32'd1);

        // Fill the whole array so every later load has defined data
        for (int i = 0; i < int'(DEPTH) / 4; i++)
            run(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "init", rd, re);

        run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w", rd, re);
        run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w", rd, re);
        chk("ld_w.val", rd, 32'hDEADBEEF);
        run(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, "ld_bs", rd, re);
        chk("ld_bs.val", rd, 32'hFFFFFFAD);
        run(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, "ld_bu", rd, re);
        chk("ld_bu.val", rd, 32'h000000AD);

        run(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF7F01, "st_h", rd, re);
        run(1'b1, 2'd0, 1'b0, 32'h21, 32'h12345680, "st_b", rd, re);
        run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "ld_w20", rd, re);
        chk("ld_w20.low24", rd & 32'h00FFFFFF, 32'h00807F01);
        run(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "ld_hs", rd, re);
        chk("ld_hs.val", rd, 32'h00007F01);

        run(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, "mis_w", rd, re);
        chk("mis_w.err", 32'(re), 32'd1);
        run(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, "mis_h", rd, re);
        chk("mis_h.err", 32'(re), 32'd1);
        run(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, "ill_ld", rd, re);
        chk("ill_ld.err", 32'(re), 32'd1);
        run(1'b1, 2'd3, 1'b0, 32'h10, 32'h11111111, "ill_st", rd, re);
        run(1'b1, 2'd2, 1'b0, 32'h12, 32'h22222222, "mis_st", rd, re);
        run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_after_err", rd, re);
        chk("ld_after_err.val", rd, 32'hDEADBEEF);

        run(1'b1, 2'd0, 1'b0, 32'h104, 32'h0000005A, "wrap_st", rd, re);
        run(1'b0, 2'd0, 1'b1, 32'h04, 32'h0, "wrap_ld", rd, re);
        chk("wrap_ld.val", rd, 32'h0000005A);

        for (int i = 0; i < 200; i++) begin
            logic [1:0]  rsz;
            logic [31:0] raddr;
            rsz   = 2'($urandom);
            raddr = $urandom;
            if ($urandom_range(3) != 0)
                raddr = (rsz == 2'd1) ? (raddr & ~32'd1) : (rsz == 2'd2) ? (raddr & ~32'd3) : raddr;
            run(1'($urandom), rsz, 1'($urandom), raddr, $urandom, "rand", rd, re);
        end

        // Reset during WAIT of a store must leave the array untouched
        old30 = {ref_mem[32'h30], ref_mem[32'h31], ref_mem[32'h32], ref_mem[32'h33]};
        @(negedge clk);
        we = 1'b1; size = 2'd2; uns = 1'b0; a = 32'h30; di = ~old30; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("abort.busy", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort.ready", 32'(ready), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        chk("abort.nodone", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.ready_after", 32'(ready), 32'd1);
        chk("abort.done_after", 32'(done), 32'd0);
        run(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "abort_ld", rd, re);
        chk("abort_ld.val", rd, old30);

        // WAIT=3 instance with req held: one access per 5 cycles, no queueing
        @(negedge clk);
        chk("tp.ready0", 32'(ready3), 32'd1);
        we3 = 1'b1; size3 = 2'd2; uns3 = 1'b0; a3 = 32'h40; di3 = 32'h0BADF00D; req3 = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 24; n++) begin
            logic e_done, e_ready;
            @(posedge clk);
            #1;
            e_done  = (n % 5 == 4) && (n <= 19);
            e_ready = (n % 5 == 0) || (n >= 20);
            chk($sformatf("tp.done%0d", n), 32'(done3), 32'(e_done));
            chk($sformatf("tp.ready%0d", n), 32'(ready3), 32'(e_ready));
            if (done3 === 1'b1) begin
                ndone++;
                chk("tp.err", 32'(err3), 32'd0);
                chk("tp.do", dout3, 32'd0);
            end
            if (n == 17) req3 = 1'b0;
        end
        chk("tp.count", 32'(ndone), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datamem_sized.md
# datamem_sized

Clocked, byte-addressed, big-endian data memory for the pipelined CPU's MEM stage. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Accesses use a request/ready/done handshake with a parametrised number of wait states, and misaligned or illegal accesses are flagged with an error instead of corrupting memory. It replaces the combinational word-only data memory, and the MEM stage stalls on `ready`/`done`.

## Interface
Parameters:
- `DEPTH_BYTES`, 256: array size in bytes; power of two, ≥ 4.
- `WAIT`, 1: wait-state cycles per access, 0..7.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  1  access request; sampled only while `ready`=1.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `uns`  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- `a`  in  32  byte address; only the low log2(DEPTH_BYTES) bits are used, so addresses wrap modulo DEPTH_BYTES.
- `di`  in  32  store data, right-justified.
- `ready`  out  1  block is idle and will accept `req`.
- `done`  out  1  one-cycle pulse when an access completes.
- `do`  out  32  load result; valid on `done`, held until the next `done`.
- `err`  out  1  valid with `done`; access was misaligned or illegal.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: `ready`=1.
  - `req`=1 in IDLE: capture `a`, `we`, `size`, `uns`, `di`. Go to WAIT if `WAIT`>0, otherwise go straight to RESP.
  - WAIT: a counter loads `WAIT`-1 on entry and decrements each cycle. At 0 the FSM goes to RESP.
  - RESP: assert `done` for exactly one cycle, then return to IDLE.
- **Error check**, on captured fields:
  - `size`=11 is an error.
  - Half with `a[0]`=1 is an error.
  - Word with `a[1:0]`≠0 is an error.
  - On error: no array write, `do`=0, `err`=1 with `done`.
- **Stores are big-endian** (lowest address holds the MSB):
  - Byte: `di[7:0]`→`mem[a]`.
  - Half: `di[15:8]`→`a`, `di[7:0]`→`a+1`.
  - Word: `di[31:24]`→`a` … `di[7:0]`→`a+3`.
  - Bits of `di` outside the access size are ignored.
- **Loads:**
  - Byte: result = `mem[a]`.
  - Half: result = `{mem[a],mem[a+1]}`.
  - Word: result = `{mem[a]..mem[a+3]}`.
  - Byte and half results are extended to 32 bits: sign-extended when `uns`=0, zero-extended when `uns`=1.
  - For a successful store, `do` = 0.
- Aligned accesses never straddle the top of the array, because `DEPTH_BYTES` is a multiple of 4.
- Array contents are not reset; they are undefined until written.

## Timing
- **Reset values:**
  - While `rst_n`=0: `ready`=0, `done`=0, `err`=0, `do`=0, FSM in IDLE.
  - `ready`=1 in the first cycle after deassertion.
- **Latency:** request accepted at edge T → `done` high in cycle T+1+`WAIT`.
- **Throughput:** one access per `WAIT`+2 cycles.
- **`ready` timing:** low from T+1 through the `done` cycle; high the cycle after `done`.
- **Store commit:** at the edge entering RESP. A load accepted after a store's `done` returns the new data.
- **`req` while busy:** ignored; no queueing. The master must hold `req` until it sees `ready`.
- **`err` and `do`:** update only at the edge that raises `done`; they hold their values otherwise.
- **Reset mid-access:**
  - In WAIT: the access is aborted, no write occurs, and no `done` is produced.
  - In RESP: the commit has already happened.

## Test plan
- `WAIT`=1: store word `a`=0x10, `di`=0xDEADBEEF → `done` at T+2. Then load word 0x10 → `do`=0xDEADBEEF; byte load of 0x11 with `uns`=0 → 0xFFFFFFAD; with `uns`=1 → 0x000000AD.
- Store half 0x7F01 at `a`=0x22, then store byte 0x80 at 0x21 → load word 0x20 returns bits [23:0] = 0x807F01. Signed half load at 0x22 → 0x00007F01.
- Load word at `a`=0x13, half at `a`=0x05, and `size`=11 → each returns `err`=1, `do`=0. A following load word at 0x10 is unchanged.
- `DEPTH_BYTES`=256: store byte 0x5A at `a`=0x104 → load byte at `a`=0x04 returns 0x5A.
- `WAIT`=3, `req` held high continuously: `done` pulses every 5 cycles, `ready` is low for 4 cycles per access, and extra requests are not queued.
- Assert `rst_n` low during WAIT of a store to 0x30 → no `done`, and the old contents of 0x30 are intact. After release, `ready`=1 on the first cycle.
